uart_word_tx_arbiter: RTL and testbench

Scheduler in front of the byte-wide UART transmit path of the 32-bit-word UART module.
- Accepts whole words from NUM_REQ independent requesters and arbitrates between them round-robin.
- Serialises the granted word LSB-byte-first into the transmitter's byte handshake.
- Enforces a programmable idle gap between words.
- Reports which requester owns the link and counts completed words.

---
 rtl/uart_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/uart_word_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_uart_word_tx_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the 32-bit-word UART datapath.
package uart_pkg;

    localparam int unsigned WORD_WIDTH_DEF = 32;
    localparam int unsigned BYTE_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } tx_sched_state_t;

    typedef logic [BYTE_WIDTH_DEF-1:0] byte_t;

    function automatic int unsigned nbytes(input int unsigned word_w, input int unsigned byte_w);
        return word_w / byte_w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after rr_ptr wins.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_grant
);

    logic [IDX_W-1:0] cand;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = '0;
        if (enable) begin
            for (int unsigned off = 0; off < NUM_REQ; off++) begin
                cand = IDX_W'((32'(rr_ptr) + off) % NUM_REQ);
                if (!any_grant && req[cand]) begin
                    any_grant   = 1'b1;
                    grant_idx   = cand;
                    grant[cand] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_word_tx_arbiter.sv
// Round-robin word scheduler feeding the byte-wide UART transmitter, LSB byte first.
module uart_word_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int unsigned WORD_WIDTH = WORD_WIDTH_DEF,
    parameter  int unsigned BYTE_WIDTH = BYTE_WIDTH_DEF,
    parameter  int unsigned NUM_REQ    = 2,
    parameter  int unsigned GAP_CYCLES = 0,
    localparam int unsigned ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          byte_valid,
    output logic [BYTE_WIDTH-1:0]         byte_data,
    input  logic                          byte_ready,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic [15:0]                   words_sent
);

    localparam int unsigned NBYTES = nbytes(WORD_WIDTH, BYTE_WIDTH);
    localparam int unsigned IDX_BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    if ((WORD_WIDTH % BYTE_WIDTH) != 0 || NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES > 255) begin : g_param_check
        $error("uart_word_tx_arbiter: illegal parameter combination");
    end

    tx_sched_state_t        state_q, state_d;
    logic [WORD_WIDTH-1:0]  shadow_q, shadow_d;
    logic [IDX_BW-1:0]      idx_q, idx_d;
    logic [7:0]             gap_q, gap_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]        grant_q, grant_d;
    logic [15:0]            words_q, words_d;

    logic [NUM_REQ-1:0]     arb_grant;
    logic [ID_W-1:0]        arb_idx;
    logic                   arb_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .enable    (state_q == IDLE),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_grant (arb_any)
    );

    // The capture pulse is suppressed while reset is held so no word is lost into a flop being cleared.
    assign req_ready  = arb_grant & {NUM_REQ{reset}};
    assign byte_valid = (state_q == SEND);
    assign byte_data  = shadow_q[idx_q*BYTE_WIDTH +: BYTE_WIDTH];
    assign busy       = (state_q != IDLE);
    assign grant_id   = grant_q;
    assign words_sent = words_q;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        words_d  = words_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    shadow_d = req_data[arb_idx*WORD_WIDTH +: WORD_WIDTH];
                    grant_d  = arb_idx;
                    rr_ptr_d = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    idx_d    = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (byte_ready) begin
                    if (idx_q == IDX_BW'(NBYTES - 1)) begin
                        words_d = words_q + 16'd1;
                        idx_d   = '0;
                        if (GAP_CYCLES > 0) begin
                            gap_d   = 8'(GAP_CYCLES - 1);
                            state_d = GAP;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            gap_q    <= '0;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            words_q  <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            words_q  <= words_d;
        end
    end

endmodule

// File: tb/tb_uart_word_tx_arbiter.sv
// Bench: two scheduler instances (2 requesters/no gap, 3 requesters/3-cycle gap) against a word-level model.
module tb_uart_word_tx_arbiter;

    localparam int NB   = 4;
    localparam int NR0  = 2;
    localparam int NR1  = 3;
    localparam int GAP1 = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [2:0]  in_valid [2];
    logic [31:0] in_data  [2][3];
    logic        in_br    [2];

    logic [NR0-1:0]    a_valid, a_ready;
    logic [NR0*32-1:0] a_data;
    logic              a_bv, a_br, a_busy;
    logic [7:0]        a_bd;
    logic [0:0]        a_gid;
    logic [15:0]       a_ws;

    logic [NR1-1:0]    b_valid, b_ready;
    logic [NR1*32-1:0] b_data;
    logic              b_bv, b_br, b_busy;
    logic [7:0]        b_bd;
    logic [1:0]        b_gid;
    logic [15:0]       b_ws;

    assign a_valid = in_valid[0][1:0];
    assign a_data  = {in_data[0][1], in_data[0][0]};
    assign a_br    = in_br[0];
    assign b_valid = in_valid[1];
    assign b_data  = {in_data[1][2], in_data[1][1], in_data[1][0]};
    assign b_br    = in_br[1];

    uart_word_tx_arbiter #(.NUM_REQ(NR0), .GAP_CYCLES(0)) dut_a (
        .clock(clock), .reset(reset), .req_valid(a_valid), .req_data(a_data), .req_ready(a_ready),
        .byte_valid(a_bv), .byte_data(a_bd), .byte_ready(a_br), .grant_id(a_gid), .busy(a_busy),
        .words_sent(a_ws)
    );

    uart_word_tx_arbiter #(.NUM_REQ(NR1), .GAP_CYCLES(GAP1)) dut_b (
        .clock(clock), .reset(reset), .req_valid(b_valid), .req_data(b_data), .req_ready(b_ready),
        .byte_valid(b_bv), .byte_data(b_bd), .byte_ready(b_br), .grant_id(b_gid), .busy(b_busy),
        .words_sent(b_ws)
    );

    logic [2:0]  obs_ready [2];
    logic        obs_bv    [2];
    logic [7:0]  obs_bd    [2];
    logic [1:0]  obs_gid   [2];
    logic        obs_busy  [2];
    logic [15:0] obs_ws    [2];

    assign obs_ready[0] = {1'b0, a_ready};
    assign obs_ready[1] = b_ready;
    assign obs_bv[0]    = a_bv;
    assign obs_bv[1]    = b_bv;
    assign obs_bd[0]    = a_bd;
    assign obs_bd[1]    = b_bd;
    assign obs_gid[0]   = {1'b0, a_gid};
    assign obs_gid[1]   = b_gid;
    assign obs_busy[0]  = a_busy;
    assign obs_busy[1]  = b_busy;
    assign obs_ws[0]    = a_ws;
    assign obs_ws[1]    = b_ws;

    // Word-level reference: word in flight, bytes still owed, gap cycles still owed.
    logic [31:0] m_word [2];
    int          m_left [2];
    int          m_gap  [2];
    int          m_rr   [2];
    int          m_gid  [2];
    int          m_ws   [2];
    int          last_g [2];
    int          policy [2];   // 0: granted requester drops, 1: hold everything, 2: random

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int nr(input int k);
        return (k == 0) ? NR0 : NR1;
    endfunction

    function automatic int gap_of(input int k);
        return (k == 0) ? 0 : GAP1;
    endfunction

    function automatic int winner(input int k);
        for (int off = 0; off < nr(k); off++) begin
            int c;
            c = (m_rr[k] + off) % nr(k);
            if (in_valid[k][c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_word[k] = '0;
            m_left[k] = 0;
            m_gap[k]  = 0;
            m_rr[k]   = 0;
            m_gid[k]  = 0;
            m_ws[k]   = 0;
            last_g[k] = -1;
        end
    endtask

    task automatic check_dut(input int k);
        bit   idle;
        int   g;
        logic [31:0] exp_ready;
        idle      = (m_left[k] == 0) && (m_gap[k] == 0);
        g         = winner(k);
        exp_ready = (reset && idle && g >= 0) ? (32'd1 << g) : 32'd0;
        check($sformatf("req_ready[%0d]", k), {29'd0, obs_ready[k]}, exp_ready);
        check($sformatf("byte_valid[%0d]", k), {31'd0, obs_bv[k]}, {31'd0, m_left[k] > 0});
        if (m_left[k] > 0)
            check($sformatf("byte_data[%0d]", k), {24'd0, obs_bd[k]},
                  (m_word[k] >> (8 * (NB - m_left[k]))) & 32'hFF);
        check($sformatf("busy[%0d]", k), {31'd0, obs_busy[k]}, {31'd0, !idle});
        check($sformatf("grant_id[%0d]", k), {30'd0, obs_gid[k]}, m_gid[k]);
        check($sformatf("words_sent[%0d]", k), {16'd0, obs_ws[k]}, m_ws[k]);
    endtask

    task automatic step(input int k);
        bit idle;
        int g;
        last_g[k] = -1;
        if (!reset) return;
        idle = (m_left[k] == 0) && (m_gap[k] == 0);
        g    = winner(k);
        if (idle && g >= 0) begin
            m_word[k] = in_data[k][g];
            m_left[k] = NB;
            m_rr[k]   = (g + 1) % nr(k);
            m_gid[k]  = g;
            last_g[k] = g;
        end else if (m_left[k] > 0) begin
            if (in_br[k]) begin
                m_left[k]--;
                if (m_left[k] == 0) begin
                    m_ws[k]  = (m_ws[k] + 1) % 65536;
                    m_gap[k] = gap_of(k);
                end
            end
        end else if (m_gap[k] > 0) begin
            m_gap[k]--;
        end
    endtask

    task automatic drive(input int k);
        case (policy[k])
            0: if (last_g[k] >= 0) in_valid[k][last_g[k]] = 1'b0;
            1: ;
            default: begin
                for (int i = 0; i < nr(k); i++) begin
                    if (in_valid[k][i]) begin
                        if (i == last_g[k]) begin
                            if ($urandom_range(1, 0) == 1) in_data[k][i] = $urandom();
                            else in_valid[k][i] = 1'b0;
                        end else if ($urandom_range(15, 0) == 0) begin
                            in_valid[k][i] = 1'b0;
                        end
                    end else if ($urandom_range(2, 0) == 0) begin
                        in_valid[k][i] = 1'b1;
                        in_data[k][i]  = $urandom();
                    end
                end
                in_br[k] = ($urandom_range(3, 0) != 0);
            end
        endcase
    endtask

    // Check just before the falling edge settles into the next rising edge; drive just after the rising edge.
    task automatic cycle();
        @(negedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            check_dut(k);
            step(k);
        end
        @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) drive(k);
    endtask

    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_bv_a", {31'd0, a_bv}, 32'd0);
        check("rst_busy_a", {31'd0, a_busy}, 32'd0);
        check("rst_ws_a", {16'd0, a_ws}, 32'd0);
        check("rst_bd_a", {24'd0, a_bd}, 32'd0);
        check("rst_bv_b", {31'd0, b_bv}, 32'd0);
        check("rst_busy_b", {31'd0, b_busy}, 32'd0);
        check("rst_ws_b", {16'd0, b_ws}, 32'd0);
        model_reset();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = '0;
            in_br[k]    = 1'b1;
            policy[k]   = 0;
            for (int i = 0; i < 3; i++) in_data[k][i] = '0;
        end
        model_reset();
        repeat (3) cycle();
        reset = 1'b1;

        // Single word, byte_ready high.
        in_data[0][0]  = 32'hAABBCCDD;
        in_valid[0][0] = 1'b1;
        repeat (8) cycle();
        check("t1_words", {16'd0, a_ws}, 32'd1);
        check("t1_gid", {31'd0, a_gid}, 32'd0);

        // Two requesters contending, no gap.
        in_data[0][0] = 32'h11223344;
        in_data[0][1] = 32'h55667788;
        in_valid[0]   = 3'b011;
        policy[0]     = 1;
        repeat (21) cycle();
        in_valid[0] = '0;
        policy[0]   = 0;
        repeat (6) cycle();

        // Backpressure while byte index 1 is presented.
        in_data[0][0]  = 32'hAABBCCDD;
        in_valid[0][0] = 1'b1;
        for (int i = 0; i < 10 && m_left[0] != 3; i++) cycle();
        in_br[0] = 1'b0;
        repeat (5) cycle();
        in_br[0] = 1'b1;
        repeat (6) cycle();

        // Three-cycle gap on the second instance, requester 1 always valid.
        in_data[1][1]  = 32'hA1B2C3D4;
        in_valid[1][1] = 1'b1;
        policy[1]      = 1;
        repeat (26) cycle();
        in_valid[1] = '0;
        policy[1]   = 0;
        repeat (10) cycle();

        // Asynchronous reset while byte 2 is on the link.
        in_data[0][0] = 32'hCAFEF00D;
        in_data[0][1] = 32'h0BADBEEF;
        in_valid[0]   = 3'b011;
        policy[0]     = 1;
        for (int i = 0; i < 10 && m_left[0] != 2; i++) cycle();
        async_reset();
        repeat (2) cycle();
        reset = 1'b1;
        repeat (2) cycle();
        check("t5_gid", {31'd0, a_gid}, 32'd0);
        in_valid[0] = '0;
        policy[0]   = 0;
        for (int i = 0; i < 12 && (m_left[0] != 0 || m_gap[0] != 0); i++) cycle();

        // Word counter wrap.
        force dut_a.words_q = 16'hFFFF;
        #1 release dut_a.words_q;
        m_ws[0]        = 16'hFFFF;
        in_data[0][1]  = 32'h01020304;
        in_valid[0][1] = 1'b1;
        repeat (8) cycle();
        check("t6_wrap", {16'd0, a_ws}, 32'd0);

        // Randomised traffic on both instances, with one reset in the middle.
        policy[0] = 2;
        policy[1] = 2;
        for (int i = 0; i < 3000; i++) begin
            cycle();
            if (i == 1500) begin
                async_reset();
                repeat (2) cycle();
                reset = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
